// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction-fetch front end.
//   fetch_state_t : fetch FSM states (IDLE, FETCH)
//   pc_sel_t      : encoded PC-update source, one per cycle
//   pc_select()   : priority encoder ret > call > jump > branch > inc
package cpu_pkg;

   typedef enum logic [0:0] {
      FS_IDLE  = 1'b0,
      FS_FETCH = 1'b1
   } fetch_state_t;

   typedef enum logic [2:0] {
      PCS_HOLD   = 3'd0,
      PCS_INC    = 3'd1,
      PCS_BRANCH = 3'd2,
      PCS_JUMP   = 3'd3,
      PCS_CALL   = 3'd4,
      PCS_RET    = 3'd5
   } pc_sel_t;

   function automatic pc_sel_t pc_select(input logic ret, input logic call,
                                         input logic jump, input logic branch,
                                         input logic inc);
      if (ret)         return PCS_RET;
      else if (call)   return PCS_CALL;
      else if (jump)   return PCS_JUMP;
      else if (branch) return PCS_BRANCH;
      else if (inc)    return PCS_INC;
      else             return PCS_HOLD;
   endfunction

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// cpu_fetch_unit_if: instruction-memory bus between the fetch unit and memory.
//   mem_req   : fetch request (fetch unit -> memory)
//   Address   : memory address (fetch unit -> memory)
//   mem_ack   : read data valid this cycle (memory -> fetch unit)
//   mem_rdata : instruction word (memory -> fetch unit)
interface cpu_fetch_unit_if #(
   parameter int DW = 16
);
   logic          mem_req;
   logic [DW-1:0] Address;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   modport master (output mem_req, output Address, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input Address, output mem_ack, output mem_rdata);
endinterface

// File: rtl/ras_stack.sv
// ras_stack: return-address LIFO.
//   clk, reset : clock, asynchronous active-high reset (pointer only)
//   push, pop  : push din / pop top; ignored when full / empty respectively
//   din        : value to push
//   top        : most recently pushed entry (0 when empty)
//   full,empty : occupancy status
module ras_stack #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] top,
   output logic          full,
   output logic          empty
);
   localparam int PW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] ptr;

   assign empty = (ptr == '0);
   assign full  = (ptr == PW'(DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + PW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - PW'(1);
      end
   end

   // Entry storage is not reset: the pointer alone defines what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && !full && ptr == PW'(i)) mem[i] <= din;
      end
   end

   // Compare-based read keeps the index width independent of DEPTH.
   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ptr == PW'(i + 1)) top = mem[i];
      end
   end
endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: program counter, instruction register and fetch FSM with a
// return-address stack.
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : instruction-memory bus (mem_req/Address out, mem_ack/mem_rdata in)
//   fetch_start  : start a fetch at the (possibly just updated) PC
//   flush        : abort an in-progress fetch; wins over mem_ack
//   ret/call/jump_take/branch_take/pc_inc : PC controls, sampled in IDLE only
//   jump_target  : absolute target for jump and call
//   adr_sel      : in IDLE, put reg_addr (1) or PC (0) on Address
//   reg_addr     : data address from the datapath
//   pc_out, ir_out, ir_valid : PC, IR, one-cycle IR-loaded pulse
//   ras_full, ras_empty, ras_err : stack status, sticky over/underflow
module cpu_fetch_unit
   import cpu_pkg::*;
#(
   parameter int            DW        = 16,
   parameter int            OFS_W     = 8,
   parameter int            RAS_DEPTH = 4,
   parameter logic [DW-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   cpu_fetch_unit_if.master     bus,
   input  logic                 fetch_start,
   input  logic                 flush,
   input  logic                 branch_take,
   input  logic                 jump_take,
   input  logic                 call,
   input  logic                 ret,
   input  logic                 pc_inc,
   input  logic [DW-1:0]        jump_target,
   input  logic                 adr_sel,
   input  logic [DW-1:0]        reg_addr,
   output logic [DW-1:0]        pc_out,
   output logic [DW-1:0]        ir_out,
   output logic                 ir_valid,
   output logic                 ras_full,
   output logic                 ras_empty,
   output logic                 ras_err
);
   localparam logic [0:0] IDLE  = FS_IDLE;
   localparam logic [0:0] FETCH = FS_FETCH;

   logic [0:0]    state;
   logic [DW-1:0] pc;
   logic [DW-1:0] ir;
   logic [DW-1:0] pc_next;
   logic [DW-1:0] ras_top;
   logic          ras_push;
   logic          ras_pop;
   logic          err_set;
   logic          in_idle;
   pc_sel_t       sel;

   function automatic logic [DW-1:0] branch_offset(input logic [OFS_W-1:0] field);
      logic signed [OFS_W-1:0] ofs;
      logic signed [DW-1:0]    ext;
      ofs = field;
      ext = DW'(ofs);
      return ext;
   endfunction

   assign in_idle = (state == IDLE);
   assign sel     = pc_select(ret, call, jump_take, branch_take, pc_inc);

   ras_stack #(.DW(DW), .DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pc),
      .top   (ras_top),
      .full  (ras_full),
      .empty (ras_empty)
   );

   // Single next-PC source per cycle; stack side effects follow the same selection.
   always_comb begin
      pc_next  = pc;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      err_set  = 1'b0;
      if (in_idle) begin
         case (sel)
            PCS_RET: begin
               if (!ras_empty) begin
                  pc_next = ras_top;
                  ras_pop = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
            PCS_CALL: begin
               pc_next = jump_target;
               if (!ras_full) ras_push = 1'b1;
               else           err_set  = 1'b1;
            end
            PCS_JUMP:   pc_next = jump_target;
            PCS_BRANCH: pc_next = pc + branch_offset(ir[OFS_W-1:0]);
            PCS_INC:    pc_next = pc + DW'(1);
            default:    pc_next = pc;
         endcase
      end else if (!flush && bus.mem_ack) begin
         pc_next = pc + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         ir       <= '0;
         ir_valid <= 1'b0;
         ras_err  <= 1'b0;
      end else begin
         pc       <= pc_next;
         ir_valid <= 1'b0;
         if (err_set) ras_err <= 1'b1;
         case (state)
            IDLE: begin
               if (fetch_start && !flush) state <= FETCH;
            end
            default: begin
               if (flush) begin
                  state <= IDLE;
               end else if (bus.mem_ack) begin
                  ir       <= bus.mem_rdata;
                  ir_valid <= 1'b1;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.mem_req = (state == FETCH);
   // In FETCH the address is pinned to PC regardless of adr_sel.
   assign bus.Address = (state == FETCH || !adr_sel) ? pc : reg_addr;
   assign pc_out      = pc;
   assign ir_out      = ir;
endmodule

// File: tb/tb_cpu_fetch_unit.sv
module tb_cpu_fetch_unit;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic        fetch_start, flush, branch_take, jump_take, call, ret, pc_inc, adr_sel;
   logic [15:0] jump_target, reg_addr;
   logic [15:0] pc_out, ir_out;
   logic        ir_valid, ras_full, ras_empty, ras_err;

   cpu_fetch_unit_if #(.DW(16)) bus ();

   cpu_fetch_unit #(.DW(16), .OFS_W(8), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .fetch_start(fetch_start), .flush(flush), .branch_take(branch_take),
      .jump_take(jump_take), .call(call), .ret(ret), .pc_inc(pc_inc),
      .jump_target(jump_target), .adr_sel(adr_sel), .reg_addr(reg_addr),
      .pc_out(pc_out), .ir_out(ir_out), .ir_valid(ir_valid),
      .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: fetch flag, PC, IR, stack as a queue.
   bit          m_fetch;
   logic [15:0] m_pc, m_ir;
   bit          m_valid;
   bit          m_err;
   logic [15:0] m_stack[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fetch = 0; m_pc = 16'h0000; m_ir = 16'h0000; m_valid = 0; m_err = 0;
      m_stack.delete();
   endtask

   task automatic model_step();
      m_valid = 0;
      if (reset) begin
         model_reset();
      end else if (!m_fetch) begin
         if (ret) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else m_err = 1;
         end else if (call) begin
            if (m_stack.size() < 4) m_stack.push_back(m_pc);
            else m_err = 1;
            m_pc = jump_target;
         end else if (jump_take) begin
            m_pc = jump_target;
         end else if (branch_take) begin
            m_pc = m_pc + {{8{m_ir[7]}}, m_ir[7:0]};
         end else if (pc_inc) begin
            m_pc = m_pc + 16'd1;
         end
         if (fetch_start && !flush) m_fetch = 1;
      end else if (flush) begin
         m_fetch = 0;
      end else if (bus.mem_ack) begin
         m_ir = bus.mem_rdata;
         m_pc = m_pc + 16'd1;
         m_valid = 1;
         m_fetch = 0;
      end
   endtask

   // One cycle: model and DUT advance on the same edge, inputs change 1 ns later.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_ctl();
      fetch_start = 0; flush = 0; branch_take = 0; jump_take = 0;
      call = 0; ret = 0; pc_inc = 0; bus.mem_ack = 0;
   endtask

   always @(negedge clk) begin
      chk("pc_out", pc_out, m_pc);
      chk("ir_out", ir_out, m_ir);
      chk("ir_valid", {15'd0, ir_valid}, {15'd0, m_valid});
      chk("mem_req", {15'd0, bus.mem_req}, {15'd0, m_fetch});
      chk("Address", bus.Address, (m_fetch || !adr_sel) ? m_pc : reg_addr);
      chk("ras_full", {15'd0, ras_full}, {15'd0, m_stack.size() == 4});
      chk("ras_empty", {15'd0, ras_empty}, {15'd0, m_stack.size() == 0});
      chk("ras_err", {15'd0, ras_err}, {15'd0, m_err});
   end

   logic [15:0] exp_ret [4];
   int          nreq, naddr;

   initial begin
      clear_ctl();
      adr_sel = 0; jump_target = 0; reg_addr = 0; bus.mem_rdata = 0;
      reset = 1;
      model_reset();
      cyc(); cyc();
      reset = 0;
      chk("reset_pc", pc_out, 16'h0000);
      chk("reset_ir", ir_out, 16'h0000);
      chk("reset_empty", {15'd0, ras_empty}, 16'd1);
      chk("reset_req", {15'd0, bus.mem_req}, 16'd0);

      // Zero-wait fetch.
      fetch_start = 1; bus.mem_ack = 1; bus.mem_rdata = 16'h12F0;
      cyc();
      fetch_start = 0;
      chk("f1_req", {15'd0, bus.mem_req}, 16'd1);
      chk("f1_valid0", {15'd0, ir_valid}, 16'd0);
      cyc();
      chk("f1_ir", ir_out, 16'h12F0);
      chk("f1_pc", pc_out, 16'h0001);
      chk("f1_valid1", {15'd0, ir_valid}, 16'd1);
      bus.mem_ack = 0;
      cyc();
      chk("f1_valid_pulse", {15'd0, ir_valid}, 16'd0);

      // Three wait states with PC controls asserted during FETCH.
      fetch_start = 1; adr_sel = 1; reg_addr = 16'hAAAA; bus.mem_rdata = 16'hABCD;
      cyc();
      fetch_start = 0; pc_inc = 1; jump_take = 1; jump_target = 16'h5555;
      nreq = 0; naddr = 0;
      for (int k = 0; k < 4; k++) begin
         if (bus.mem_req) nreq++;
         if (bus.Address == 16'h0001) naddr++;
         if (k == 3) bus.mem_ack = 1;
         cyc();
      end
      clear_ctl();
      chk("ws_req_cycles", 16'(nreq), 16'd4);
      chk("ws_addr_cycles", 16'(naddr), 16'd4);
      chk("ws_pc", pc_out, 16'h0002);
      chk("ws_ir", ir_out, 16'hABCD);
      adr_sel = 0;

      // Jump and fetch_start together: fetch uses the new PC.
      fetch_start = 1; jump_take = 1; jump_target = 16'h000F; bus.mem_rdata = 16'h12F0;
      cyc();
      clear_ctl();
      chk("jf_addr", bus.Address, 16'h000F);
      bus.mem_ack = 1;
      cyc();
      clear_ctl();
      chk("jf_pc", pc_out, 16'h0010);

      // Negative branch and PC wrap.
      branch_take = 1;
      cyc();
      clear_ctl();
      chk("branch_neg", pc_out, 16'h0000);
      jump_take = 1; jump_target = 16'hFFFF;
      cyc();
      clear_ctl();
      pc_inc = 1;
      cyc();
      clear_ctl();
      chk("pc_wrap", pc_out, 16'h0000);

      // Five calls into a four-deep stack.
      for (int i = 1; i <= 5; i++) begin
         call = 1; jump_target = 16'(i * 256);
         cyc();
         clear_ctl();
         if (i == 4) begin
            chk("call4_full", {15'd0, ras_full}, 16'd1);
            chk("call4_err", {15'd0, ras_err}, 16'd0);
         end
      end
      chk("call5_err", {15'd0, ras_err}, 16'd1);
      chk("call5_pc", pc_out, 16'h0500);
      exp_ret[0] = 16'h0300; exp_ret[1] = 16'h0200; exp_ret[2] = 16'h0100; exp_ret[3] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         ret = 1;
         cyc();
         clear_ctl();
         chk("ret_lifo", pc_out, exp_ret[i]);
      end
      ret = 1;
      cyc();
      clear_ctl();
      chk("ret_under_pc", pc_out, 16'h0000);
      chk("ret_under_err", {15'd0, ras_err}, 16'd1);
      chk("ret_under_empty", {15'd0, ras_empty}, 16'd1);

      // flush and mem_ack in the same FETCH cycle.
      fetch_start = 1;
      cyc();
      clear_ctl();
      flush = 1; bus.mem_ack = 1; bus.mem_rdata = 16'h7777;
      cyc();
      clear_ctl();
      chk("flush_ir", ir_out, 16'h12F0);
      chk("flush_valid", {15'd0, ir_valid}, 16'd0);
      chk("flush_req", {15'd0, bus.mem_req}, 16'd0);
      chk("flush_pc", pc_out, 16'h0000);

      // ret and call together: pop only.
      call = 1; jump_target = 16'h0040;
      cyc();
      clear_ctl();
      ret = 1; call = 1; jump_target = 16'h0999;
      cyc();
      clear_ctl();
      chk("retcall_pc", pc_out, 16'h0000);
      chk("retcall_empty", {15'd0, ras_empty}, 16'd1);

      // Reset asserted in mid-FETCH.
      call = 1; jump_target = 16'h0123;
      cyc();
      clear_ctl();
      fetch_start = 1;
      cyc();
      clear_ctl();
      chk("rst_pre_req", {15'd0, bus.mem_req}, 16'd1);
      #2;
      reset = 1;
      model_reset();
      #1;
      chk("rst_async_req", {15'd0, bus.mem_req}, 16'd0);
      chk("rst_async_pc", pc_out, 16'h0000);
      chk("rst_async_empty", {15'd0, ras_empty}, 16'd1);
      chk("rst_async_err", {15'd0, ras_err}, 16'd0);
      cyc();
      reset = 0;
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
